// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding register per functional unit, round-robin push into the result FIFO.
// Optional `WB_ARB_BRANCH_PRIO_EN gives source 0 (branch unit) absolute priority without moving rr_ptr.
module wb_arbiter #(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  logic [NUM_SRC-1:0]    hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q [NUM_SRC];
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant;
  logic                  push_ok;
  logic [NUM_SRC-1:0]    load;

  // Round-robin scan starting at rr_ptr_q, wrapping modulo NUM_SRC.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && hold_valid_q[idx]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
`ifdef WB_ARB_BRANCH_PRIO_EN
    if (hold_valid_q[0]) grant = '0;
`endif
  end

  assign push_ok = (|hold_valid_q) && !fifo_full && !flush;

  // The granted entry drains this cycle, so it may refill on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rst && !flush &&
                     (!hold_valid_q[i] || (push_ok && (grant == IDX_W'(i))));
    end
  end

  assign load = src_valid & src_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush)                                     hold_valid_d[i] = 1'b0;
      else if (load[i])                              hold_valid_d[i] = 1'b1;
      else if (push_ok && (grant == IDX_W'(i)))      hold_valid_d[i] = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (push_ok) begin
      rr_ptr_d = (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
`ifdef WB_ARB_BRANCH_PRIO_EN
      if (grant == '0) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; hold_valid_q qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load[i]) hold_data_q[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_write_en   = push_ok;
  assign fifo_write_data = push_ok ? hold_data_q[grant] : '0;
  assign grant_idx       = push_ok ? grant : '0;
  assign busy            = |hold_valid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter (NUM_SRC=4, DATA_WIDTH=32).
// Expectations for the priority scenario follow `WB_ARB_BRANCH_PRIO_EN when it is defined.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         fifo_full;
  logic         fifo_write_en;
  logic [31:0]  fifo_write_data;
  logic [1:0]   grant_idx;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_idx       (grant_idx),
    .busy            (busy)
  );

  typedef struct {
    logic         rst;
    logic         flush;
    logic [3:0]   valid;
    logic [127:0] data;
    logic         full;
    logic [3:0]   exp_ready;
    logic         exp_we;
    logic [31:0]  exp_data;
    logic [1:0]   exp_idx;
    logic         exp_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic f, logic [3:0] v, logic [127:0] d, logic full,
                              logic [3:0] rdy, logic we, logic [31:0] wd, logic [1:0] idx,
                              logic bsy);
    vec_t x;
    x.rst = r; x.flush = f; x.valid = v; x.data = d; x.full = full;
    x.exp_ready = rdy; x.exp_we = we; x.exp_data = wd; x.exp_idx = idx; x.exp_busy = bsy;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] rdy, input logic we,
                               input logic [31:0] wd, input logic [1:0] idx, input logic bsy);
    check({tag, ".src_ready"}, 32'(src_ready), 32'(rdy));
    check({tag, ".write_en"},  32'(fifo_write_en), 32'(we));
    check({tag, ".write_data"}, fifo_write_data, wd);
    check({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".busy"},      32'(busy), 32'(bsy));
  endtask

  localparam logic [127:0] Z = '0;

  initial begin
    rst = 1'b0; flush = 1'b0; src_valid = 4'b1111; src_data = '1; fifo_full = 1'b0;

    // Reset held low with every source valid
    vt.push_back(mk(0, 0, 4'b1111, '1, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(0, 0, 4'b1111, '1, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0000, Z,  0, 4'b1111, 0, 32'h0, 2'd0, 0));
    // Source 2 streaming, one-cycle latency, same-cycle refill
    vt.push_back(mk(1, 0, 4'b0100, {32'h0, 32'hA0, 64'h0}, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0100, {32'h0, 32'hA1, 64'h0}, 0, 4'b1111, 1, 32'hA0, 2'd2, 1));
    vt.push_back(mk(1, 0, 4'b0100, {32'h0, 32'hA2, 64'h0}, 0, 4'b1111, 1, 32'hA1, 2'd2, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'hA2, 2'd2, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    // Idle flush returns rr_ptr to 0
    vt.push_back(mk(1, 1, 4'b0000, Z, 0, 4'b0000, 0, 32'h0, 2'd0, 0));
    // Round-robin fairness from rr_ptr = 0
    vt.push_back(mk(1, 0, 4'b1111, {32'h40, 32'h30, 32'h20, 32'h10}, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b0001, 1, 32'h10, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b0011, 1, 32'h20, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b0111, 1, 32'h30, 2'd2, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'h40, 2'd3, 1));
    vt.push_back(mk(1, 0, 4'b1010, {32'h40, 32'h0, 32'h20, 32'h0}, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b0111, 1, 32'h20, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'h40, 2'd3, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    // FIFO full backpressure on source 1
    vt.push_back(mk(1, 0, 4'b0010, {64'h0, 32'h55, 32'h0}, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0000, Z, 1, 4'b1101, 0, 32'h0,  2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 1, 4'b1101, 0, 32'h0,  2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 1, 4'b1101, 0, 32'h0,  2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'h55, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    // Flush with rr_ptr = 2: drops sources 0/3 and the source-2 arrival
    vt.push_back(mk(1, 0, 4'b1001, {32'h03, 64'h0, 32'h01}, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 1, 4'b0100, {32'h0, 32'h99, 64'h0},  0, 4'b0000, 0, 32'h0, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b1010, {32'h33, 32'h0, 32'h11, 32'h0}, 0, 4'b1111, 0, 32'h0, 2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b0111, 1, 32'h11, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'h33, 2'd3, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    // Sources 0 and 1 continuously valid
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1111, 0, 32'h0,  2'd0, 0));
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
`ifdef WB_ARB_BRANCH_PRIO_EN
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
`else
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1110, 1, 32'hB1, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0011, {64'h0, 32'hB1, 32'hB0}, 0, 4'b1110, 1, 32'hB1, 2'd1, 1));
`endif
    vt.push_back(mk(1, 0, 4'b0010, {64'h0, 32'hB1, 32'h0}, 0, 4'b1101, 1, 32'hB0, 2'd0, 1));
    vt.push_back(mk(1, 0, 4'b0010, {64'h0, 32'hB1, 32'h0}, 0, 4'b1111, 1, 32'hB1, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 1, 32'hB1, 2'd1, 1));
    vt.push_back(mk(1, 0, 4'b0000, Z, 0, 4'b1111, 0, 32'h0,  2'd0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst       = vt[i].rst;
      flush     = vt[i].flush;
      src_valid = vt[i].valid;
      src_data  = vt[i].data;
      fifo_full = vt[i].full;
      #1;
      check_outputs($sformatf("v%0d", i), vt[i].exp_ready, vt[i].exp_we, vt[i].exp_data,
                    vt[i].exp_idx, vt[i].exp_busy);
    end

    // Asynchronous reset in the middle of a pending push (rr_ptr = 2, source 3 loaded)
    @(negedge clk);
    src_valid = 4'b1000; src_data = {32'hDEAD, 96'h0};
    @(negedge clk);
    src_valid = 4'b0000; src_data = '0;
    #1;
    check_outputs("arst_pre", 4'b1111, 1'b1, 32'hDEAD, 2'd3, 1'b1);
    #1 rst = 1'b0;
    #1;
    check_outputs("arst_low", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs("arst_rel", 4'b1111, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    check_outputs("arst_idle", 4'b1111, 1'b0, 32'h0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
